// File: rtl/spi_byte_ctrl.sv
// spi_byte_ctrl: memory-mapped SPI master (mode 0, MSB first) for an SD card
// in SPI mode. It has a CTRL register (divider and card select), a read-only
// STATUS register and a DATA register. A byte write to DATA runs one
// full-duplex transfer. A DATA access made while busy is stalled until the
// transfer completes.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no transfer; sclk low, mosi high
//   ST_SHIFT  | transfer in flight; 16 sclk half-periods of (div+1) cycles
module spi_byte_ctrl #(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned RESET_DIV = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wr_val,
   input  logic [3:0]  bus_bytesel,
   output logic        bus_ack,
   output logic [31:0] bus_data,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(RESET_DIV);
   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sel_q, sel_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [3:0]       hcnt_q, hcnt_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic [7:0]       rx_q, rx_d;
   logic             rx_valid_q, rx_valid_d;
   logic             ack_q, ack_d;
   logic [31:0]      rdata_q, rdata_d;

   logic        shifting, tick, finishing, busy_blk;
   logic        is_wr, is_data, accept, start, data_rd, ctrl_wr;
   logic [3:0]  off;
   logic [7:0]  rd_rx;
   logic [31:0] ctrl_word, rdata;
   logic        unused_bits;

   assign unused_bits = ^{bus_addr[31:4], bus_wr_val[31:9]};

   assign shifting  = (state_q == ST_SHIFT);
   assign tick      = shifting && (cnt_q == '0);
   // The final falling edge frees the DATA register in the same cycle, so a
   // stalled DATA access is accepted on that edge and busy never drops visibly.
   assign finishing = tick && (hcnt_q == 4'd15);
   assign busy_blk  = shifting && !finishing;

   assign off     = bus_addr[3:0];
   assign is_wr   = |bus_bytesel;
   assign is_data = (off == 4'h8);
   assign accept  = cs && !ack_q && !(is_data && busy_blk);
   assign start   = accept && is_wr && is_data && bus_bytesel[0];
   assign data_rd = accept && !is_wr && is_data;
   assign ctrl_wr = accept && is_wr && (off == 4'h0);

   // A stalled read returns the byte completing on this edge.
   assign rd_rx = finishing ? rx_sh_q : rx_q;

   // Read-data mux over the register map
   always_comb begin
      ctrl_word           = '0;
      ctrl_word[DIV_W-1:0] = div_q;
      ctrl_word[8]        = sel_q;
      case (off)
         4'h0:    rdata = ctrl_word;
         4'h4:    rdata = {30'd0, rx_valid_q, shifting};
         4'h8:    rdata = {24'd0, rd_rx};
         default: rdata = '0;
      endcase
   end

   // Next-state logic for the bus side, config registers and shift engine
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      sel_d      = sel_q;
      cur_div_d  = cur_div_q;
      cnt_d      = cnt_q;
      hcnt_d     = hcnt_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      tx_d       = tx_q;
      rx_sh_d    = rx_sh_q;
      rx_d       = rx_q;
      rx_valid_d = rx_valid_q;
      ack_d      = accept;
      rdata_d    = (accept && !is_wr) ? rdata : '0;

      if (ctrl_wr) begin
         if (bus_bytesel[0]) div_d = bus_wr_val[DIV_W-1:0];
         if (bus_bytesel[1]) sel_d = bus_wr_val[8];
      end

      if (tick) begin
         cnt_d  = cur_div_q;
         hcnt_d = hcnt_q + 4'd1;
         sclk_d = ~sclk_q;
         if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[6:0], spi_miso};
         end else begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
         if (finishing) begin
            state_d    = ST_IDLE;
            sclk_d     = 1'b0;
            mosi_d     = 1'b1;
            rx_d       = rx_sh_q;
            rx_valid_d = 1'b1;
         end
      end else if (shifting) begin
         cnt_d = cnt_q - 1'b1;
      end

      if (data_rd) rx_valid_d = 1'b0;

      if (start) begin
         state_d   = ST_SHIFT;
         cur_div_d = div_q;
         cnt_d     = div_q;
         hcnt_d    = 4'd0;
         sclk_d    = 1'b0;
         mosi_d    = bus_wr_val[7];
         tx_d      = {bus_wr_val[6:0], 1'b0};
      end
   end

   // State registers; reset aborts any transfer and drops a pending ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= DIV_RST;
         sel_q      <= 1'b0;
         cur_div_q  <= DIV_RST;
         cnt_q      <= '0;
         hcnt_q     <= 4'd0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b1;
         tx_q       <= 8'd0;
         rx_sh_q    <= 8'd0;
         rx_q       <= 8'd0;
         rx_valid_q <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         sel_q      <= sel_d;
         cur_div_q  <= cur_div_d;
         cnt_q      <= cnt_d;
         hcnt_q     <= hcnt_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         tx_q       <= tx_d;
         rx_sh_q    <= rx_sh_d;
         rx_q       <= rx_d;
         rx_valid_q <= rx_valid_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus_ack  = ack_q;
   assign bus_data = rdata_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = ~sel_q;

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Testbench for spi_byte_ctrl: directed and randomized transfers checked
// against timing and data derived from the SPI frame rules.
module tb_spi_byte_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs = 1'b0;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_wr_val = '0;
   logic [3:0]  bus_bytesel = '0;
   logic        bus_ack;
   logic [31:0] bus_data;
   logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;

   spi_byte_ctrl #(.DIV_W(8), .RESET_DIV(63)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .bus_addr(bus_addr),
      .bus_wr_val(bus_wr_val), .bus_bytesel(bus_bytesel), .bus_ack(bus_ack),
      .bus_data(bus_data), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SCLK monitor: records the cycle of every toggle and mosi at rising edges
   logic sclk_prev = 1'b0;
   int   tog_cyc[$];
   logic rise_mosi[$];
   int   falls = 0;
   always @(negedge clk) begin
      if (spi_sclk !== sclk_prev) begin
         tog_cyc.push_back(cyc);
         if (spi_sclk === 1'b1) rise_mosi.push_back(spi_mosi);
         else falls++;
      end
      sclk_prev = spi_sclk;
   end

   // SPI slave model: presents slave_byte MSB first, next bit after each fall
   logic        loop_mode = 1'b1;
   logic [7:0]  slave_byte = 8'h00;
   int          fall_base = 0;
   logic [31:0] fidx;
   logic        slave_bit;
   assign fidx      = 32'(falls - fall_base);
   assign slave_bit = (fidx < 32'd8) ? slave_byte[3'(32'd7 - fidx)] : 1'b0;
   assign spi_miso  = loop_mode ? spi_mosi : slave_bit;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] bs, output logic [31:0] rdata,
                         output int t0, output int tack);
      @(posedge clk); #1;
      cs = 1'b1; bus_addr = addr; bus_wr_val = wdata; bus_bytesel = bs;
      t0 = cyc; tack = -1; rdata = '0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (bus_ack === 1'b1) begin
            rdata = bus_data; tack = cyc;
            break;
         end
      end
      cs = 1'b0; bus_bytesel = 4'd0;
      checks++;
      assert (tack >= 0) else begin
         errors++;
         $error("FAIL ack_timeout: addr 0x%0h observed no ack expected ack", addr);
      end
      if (tack >= 0) begin
         @(posedge clk); #1;
         chk("ack_single", {31'd0, bus_ack}, 32'd0);
         chk("data_idle", bus_data, 32'd0);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs,
                     output int t0, output int tack);
      logic [31:0] dummy;
      access(a, d, bs, dummy, t0, tack);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d,
                     output int t0, output int tack);
      access(a, 32'd0, 4'd0, d, t0, tack);
   endtask

   // Frame expectations: first toggle at t0+1+(D+1), 16th at t0+1+16(D+1)
   task automatic check_xfer(input string tag, input int bi, input int ri,
                             input int t0, input int d, input logic [7:0] exp_mosi);
      logic [7:0] m;
      for (int i = 0; i < 5000 && tog_cyc.size() < bi + 16; i++) @(negedge clk);
      checks++;
      assert (tog_cyc.size() >= bi + 16 && rise_mosi.size() >= ri + 8) else begin
         errors++;
         $error("FAIL %s_frame: observed %0d toggles expected 16", tag, tog_cyc.size() - bi);
      end
      if (tog_cyc.size() >= bi + 16 && rise_mosi.size() >= ri + 8) begin
         m = 8'd0;
         for (int k = 0; k < 8; k++) m = {m[6:0], rise_mosi[ri + k]};
         chk({tag, "_first_edge"}, tog_cyc[bi], t0 + 1 + (d + 1));
         chk({tag, "_last_edge"}, tog_cyc[bi + 15], t0 + 1 + 16 * (d + 1));
         chk({tag, "_mosi"}, {24'd0, m}, {24'd0, exp_mosi});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int t0, ta, t1, ta1, bi, ri, d;
      logic [7:0] b, s;

      // Reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
      chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
      chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("rst_ack", {31'd0, bus_ack}, 32'd0);
      chk("rst_data", bus_data, 32'd0);
      rst_n = 1'b1;
      rd(32'h0, r, t0, ta);
      chk("rst_ctrl", r, 32'h0000003F);
      chk("ctrl_lat", ta - t0, 1);
      rd(32'h4, r, t0, ta);
      chk("rst_status", r, 32'h0);

      // Loopback, div=0
      wr(32'h0, 32'h0, 4'b0001, t0, ta);
      loop_mode = 1'b1;
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, 32'hA5, 4'b0001, t0, ta);
      chk("lb_wr_lat", ta - t0, 1);
      check_xfer("lb", bi, ri, t0, 0, 8'hA5);
      rd(32'h4, r, t1, ta1);
      chk("lb_status_done", r, 32'h2);
      rd(32'h8, r, t1, ta1);
      chk("lb_rx", r, 32'hA5);
      rd(32'h4, r, t1, ta1);
      chk("lb_status_clr", r, 32'h0);

      // Back-to-back, div=1
      wr(32'h0, 32'h1, 4'b0001, t0, ta);
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, 32'h3C, 4'b0001, t0, ta);
      wr(32'h8, 32'hFF, 4'b0001, t1, ta1);
      chk("b2b_second_ack", ta1 - t0, 33);
      check_xfer("b2b1", bi, ri, t0, 1, 8'h3C);
      check_xfer("b2b2", bi + 16, ri + 8, t0 + 32, 1, 8'hFF);
      rd(32'h8, r, t1, ta1);
      chk("b2b_rx", r, 32'hFF);

      // Read stall, div=3
      wr(32'h0, 32'h3, 4'b0001, t0, ta);
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, 32'h81, 4'b0001, t0, ta);
      rd(32'h8, r, t1, ta1);
      chk("stall_rd_ack", ta1 - t0, 65);
      chk("stall_rd_data", r, 32'h81);
      check_xfer("stall", bi, ri, t0, 3, 8'h81);
      rd(32'h4, r, t1, ta1);
      chk("stall_status", r, 32'h0);

      // CTRL write during a transfer; slave drives miso
      loop_mode = 1'b0;
      s = 8'($urandom_range(0, 255));
      slave_byte = s; fall_base = falls;
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, 32'h5A, 4'b0001, t0, ta);
      wr(32'h0, 32'h107, 4'b0011, t1, ta1);
      chk("ctrl_busy_lat", ta1 - t1, 1);
      chk("ctrl_cs_n", {31'd0, spi_cs_n}, 32'd0);
      rd(32'h4, r, t1, ta1);
      chk("status_busy", r, 32'h1);
      check_xfer("ctrl_old", bi, ri, t0, 3, 8'h5A);
      rd(32'h8, r, t1, ta1);
      chk("ctrl_old_rx", r, {24'd0, s});
      rd(32'h0, r, t1, ta1);
      chk("ctrl_rb", r, 32'h107);
      b = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      slave_byte = s; fall_base = falls;
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, {24'd0, b}, 4'b0001, t0, ta);
      rd(32'h8, r, t1, ta1);
      chk("ctrl_new_rd_ack", ta1 - t0, 1 + 16 * 8);
      chk("ctrl_new_rx", r, {24'd0, s});
      check_xfer("ctrl_new", bi, ri, t0, 7, b);

      // Randomized transfers
      for (int n = 0; n < 6; n++) begin
         d = int'($urandom_range(0, 5));
         b = 8'($urandom_range(0, 255));
         s = 8'($urandom_range(0, 255));
         loop_mode = 1'($urandom_range(0, 1));
         wr(32'h0, 32'(d), 4'b0001, t0, ta);
         slave_byte = s; fall_base = falls;
         bi = tog_cyc.size(); ri = rise_mosi.size();
         wr(32'h8, {$urandom_range(0, 16777215), b}, 4'b0001, t0, ta);
         rd(32'h8, r, t1, ta1);
         chk("rnd_rd_ack", ta1 - t0, 1 + 16 * (d + 1));
         chk("rnd_rx", r, {24'd0, loop_mode ? b : s});
         check_xfer("rnd", bi, ri, t0, d, b);
      end
      rd(32'h0, r, t1, ta1);
      chk("rnd_ctrl_rb", r, 32'h100 | 32'(d));

      // DATA write with lane 0 clear, unmapped offsets
      bi = tog_cyc.size();
      wr(32'h8, 32'h1FF, 4'b0010, t0, ta);
      chk("nolane_lat", ta - t0, 1);
      repeat (20) @(posedge clk);
      #1;
      chk("nolane_no_sclk", tog_cyc.size(), bi);
      rd(32'h4, r, t1, ta1);
      chk("nolane_status", r, 32'h0);
      rd(32'hC, r, t1, ta1);
      chk("rd_0xC", r, 32'h0);
      wr(32'h2, 32'hFFFF_FFFF, 4'b1111, t0, ta);
      chk("unaligned_wr_lat", ta - t0, 1);
      rd(32'h2, r, t1, ta1);
      chk("rd_unaligned", r, 32'h0);
      rd(32'h0, r, t1, ta1);
      chk("unaligned_wr_ignored", r, 32'h100 | 32'(d));

      // Abort mid-transfer
      loop_mode = 1'b1;
      wr(32'h0, 32'h3, 4'b0001, t0, ta);
      wr(32'h8, 32'hC3, 4'b0001, t0, ta);
      repeat (30) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
      chk("abort_mosi", {31'd0, spi_mosi}, 32'd1);
      chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("abort_ack", {31'd0, bus_ack}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd(32'h4, r, t1, ta1);
      chk("abort_status", r, 32'h0);
      rd(32'h0, r, t1, ta1);
      chk("abort_ctrl", r, 32'h3F);
      wr(32'h0, 32'h2, 4'b0001, t0, ta);
      bi = tog_cyc.size(); ri = rise_mosi.size();
      wr(32'h8, 32'h5A, 4'b0001, t0, ta);
      rd(32'h8, r, t1, ta1);
      chk("post_abort_rd_ack", ta1 - t0, 1 + 16 * 3);
      chk("post_abort_rx", r, 32'h5A);
      check_xfer("post_abort", bi, ri, t0, 2, 8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
